// File: rtl/cam_lookup_ctrl_pkg.sv
// cam_lookup_ctrl_pkg: shared types for the cam lookup controller.
// Write FSM encoding and counter sizing helper.
package cam_lookup_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_WRITE,
    ST_HOLD,
    ST_WAIT
  } wr_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cam_res_fifo.sv
// cam_res_fifo: synchronous first-word-fall-through result FIFO.
// Depth is a power of two; count reports occupancy.
module cam_res_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic          valid,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign valid  = count != '0;
  assign do_pop = valid && pop;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The credit rule upstream must never let a push land on a full queue
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !do_pop && count == FULL)
  );

endmodule

// File: rtl/cam_lookup_ctrl.sv
// cam_lookup_ctrl: initiator-side controller for the cam core.
// Serialises table writes against in-flight lookups; results never dropped.
module cam_lookup_ctrl
  import cam_lookup_ctrl_pkg::*;
#(
  parameter int C_TCAM_ADDR_WIDTH = 5,
  parameter int C_TCAM_DATA_WIDTH = 32,
  parameter int C_LOOKUP_LATENCY  = 2,
  parameter int C_RES_DEPTH       = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         LKP_VALID,
  input  logic [C_TCAM_DATA_WIDTH-1:0] LKP_KEY,
  output logic                         LKP_READY,
  output logic                         RES_VALID,
  output logic                         RES_MATCH,
  output logic [C_TCAM_ADDR_WIDTH-1:0] RES_ADDR,
  input  logic                         RES_READY,
  input  logic                         WR_VALID,
  input  logic [C_TCAM_ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [C_TCAM_DATA_WIDTH-1:0] WR_DATA,
  output logic                         WR_READY,
  output logic                         CAM_WE,
  output logic [C_TCAM_ADDR_WIDTH-1:0] CAM_ADDR_WR,
  output logic [C_TCAM_DATA_WIDTH-1:0] CAM_DIN,
  input  logic                         CAM_BUSY,
  output logic [C_TCAM_DATA_WIDTH-1:0] CAM_CMP_DIN,
  input  logic                         CAM_MATCH,
  input  logic [C_TCAM_ADDR_WIDTH-1:0] CAM_MATCH_ADDR
);

  localparam int AW  = C_TCAM_ADDR_WIDTH;
  localparam int DW  = C_TCAM_DATA_WIDTH;
  localparam int LAT = C_LOOKUP_LATENCY;
  localparam int CW  = cnt_w(C_RES_DEPTH);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_V = CW1'(C_RES_DEPTH);

  wr_state_e     state;
  wr_state_e     state_nxt;
  logic [LAT-1:0] pipe;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          lkp_acc;
  logic          push;
  logic [AW:0]   res_din;
  logic [AW:0]   res_dout;
  logic          fifo_valid;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(pipe[i]);
    end
  end

  // Queued plus in-flight results must fit the FIFO before a new issue
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};

  assign LKP_READY = !RESET
                  && state == ST_IDLE
                  && !WR_VALID
                  && !CAM_BUSY
                  && occupancy < DEPTH_V;

  assign lkp_acc = LKP_VALID && LKP_READY;
  assign push    = pipe[LAT-1];
  assign res_din = {CAM_MATCH,
                    CAM_MATCH ? CAM_MATCH_ADDR : '0};

  cam_res_fifo #(
    .W     (AW + 1),
    .DEPTH (C_RES_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .din   (res_din),
    .pop   (RES_READY),
    .valid (fifo_valid),
    .dout  (res_dout),
    .count (fifo_count)
  );

  assign RES_VALID = fifo_valid;
  assign RES_MATCH = fifo_valid && res_dout[AW];
  assign RES_ADDR  = fifo_valid ? res_dout[AW-1:0] : '0;

  always_comb begin
    state_nxt = state;
    WR_READY  = 1'b0;
    CAM_WE    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (WR_VALID) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (inflight == '0 && !CAM_BUSY) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        CAM_WE    = !RESET;
        state_nxt = ST_HOLD;
      end
      // cam raises BUSY one cycle after WE, so skip it here
      ST_HOLD: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!CAM_BUSY) begin
          WR_READY  = !RESET;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      pipe        <= '0;
      CAM_CMP_DIN <= '0;
      CAM_ADDR_WR <= '0;
      CAM_DIN     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state <= state_nxt;
      pipe  <= (pipe << 1) | LAT'(lkp_acc);
      if (lkp_acc) begin
        CAM_CMP_DIN <= LKP_KEY;
      end
      if (state == ST_IDLE && WR_VALID) begin
        wr_addr_q <= WR_ADDR;
        wr_data_q <= WR_DATA;
      end
      if (state == ST_DRAIN && state_nxt == ST_WRITE) begin
        CAM_ADDR_WR <= wr_addr_q;
        CAM_DIN     <= wr_data_q;
      end
    end
  end

  a_credit: assert property (
    @(posedge CLK) disable iff (RESET)
    occupancy <= DEPTH_V
  );

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// tb_cam_lookup_ctrl: directed bench with a behavioural cam model
// and a queue scoreboard checked by an independent monitor.
module tb_cam_lookup_ctrl;

  typedef struct {
    logic [5:0] r;
    int         acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lkp_valid = 1'b0;
  logic [31:0] lkp_key = '0;
  logic        lkp_ready;
  logic        res_valid;
  logic        res_match;
  logic [4:0]  res_addr;
  logic        res_ready = 1'b1;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic        cam_we;
  logic [4:0]  cam_addr_wr;
  logic [31:0] cam_din;
  logic        cam_busy;
  logic [31:0] cam_cmp_din;
  logic        cam_match;
  logic [4:0]  cam_match_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pops = 0;
  exp_t exp_q[$];

  logic [31:0] ref_mem [32];
  bit          ref_vld [32];

  logic [31:0] cam_mem [32];
  bit          cam_vld [32];
  int          busy_cnt = 0;
  logic        m_q = 1'b0;
  logic [4:0]  ma_q = '0;

  wire [78:0] all_out = {lkp_ready, res_valid, res_match,
                         res_addr, wr_ready, cam_we,
                         cam_addr_wr, cam_din, cam_cmp_din};

  cam_lookup_ctrl dut (
    .CLK            (clk),
    .RESET          (rst),
    .LKP_VALID      (lkp_valid),
    .LKP_KEY        (lkp_key),
    .LKP_READY      (lkp_ready),
    .RES_VALID      (res_valid),
    .RES_MATCH      (res_match),
    .RES_ADDR       (res_addr),
    .RES_READY      (res_ready),
    .WR_VALID       (wr_valid),
    .WR_ADDR        (wr_addr),
    .WR_DATA        (wr_data),
    .WR_READY       (wr_ready),
    .CAM_WE         (cam_we),
    .CAM_ADDR_WR    (cam_addr_wr),
    .CAM_DIN        (cam_din),
    .CAM_BUSY       (cam_busy),
    .CAM_CMP_DIN    (cam_cmp_din),
    .CAM_MATCH      (cam_match),
    .CAM_MATCH_ADDR (cam_match_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cam: one compare register after CMP_DIN, BUSY 16 cycles one late
  always @(posedge clk) begin
    if (cam_we) begin
      cam_mem[cam_addr_wr] <= cam_din;
      cam_vld[cam_addr_wr] <= 1'b1;
      busy_cnt <= 17;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    m_q  <= 1'b0;
    ma_q <= 5'h15;
    for (int i = 31; i >= 0; i--) begin
      if (cam_vld[i] && cam_mem[i] == cam_cmp_din) begin
        m_q  <= 1'b1;
        ma_q <= i[4:0];
      end
    end
  end

  assign cam_busy       = busy_cnt > 0 && busy_cnt <= 16;
  assign cam_match      = m_q;
  assign cam_match_addr = ma_q;

  task automatic chk(input string nm,
                     input logic [79:0] act,
                     input logic [79:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [5:0] exp_of(input logic [31:0] k);
    for (int i = 0; i < 32; i++) begin
      if (ref_vld[i] && ref_mem[i] == k) return {1'b1, 5'(i)};
    end
    return 6'b0;
  endfunction

  task automatic push_exp(input logic [31:0] k);
    exp_t e;
    e.r   = exp_of(k);
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic lookup(input logic [31:0] k, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    lkp_valid = 1'b1;
    lkp_key   = k;
    #1;
    while (!lkp_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    acc = cyc;
    if (lkp_ready) begin
      push_exp(k);
    end else begin
      checks++;
      failures++;
      $display("FAIL lkp_timeout: key %0h not accepted", k);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                          input bit with_lkp, input logic [31:0] k,
                          output int we_c);
    int n;
    int we_n;
    bit done;
    bit leak;
    bit bad;
    bit ok;
    bit pb;
    n = 0; we_n = 0; done = 0; leak = 0;
    bad = 0; ok = 0; pb = 0; we_c = 0;
    @(negedge clk);
    wr_valid  = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    lkp_valid = with_lkp;
    lkp_key   = k;
    #1;
    while (!done && n < 300) begin
      if (lkp_ready) leak = 1;
      if (cam_we) begin
        we_n++;
        we_c = cyc;
        if (cam_addr_wr !== a || cam_din !== d) bad = 1;
      end
      if (wr_ready) begin
        done = 1;
        ok   = !cam_busy && pb;
      end else begin
        pb = cam_busy;
        @(negedge clk);
        #1;
        n++;
      end
    end
    @(negedge clk);
    wr_valid  = 1'b0;
    lkp_valid = 1'b0;
    if (done) begin
      ref_mem[a] = d;
      ref_vld[a] = 1'b1;
    end
    chk("wr_done", done, 1);
    chk("wr_we_once", we_n, 1);
    chk("wr_we_addr_data", bad, 0);
    chk("wr_ready_timing", ok, 1);
    chk("wr_lkp_blocked", leak, 0);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(nm, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard whenever a result is consumed
  initial begin
    exp_t       e;
    bit         stall;
    logic [5:0] held;
    stall = 0;
    held  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall = 0;
        continue;
      end
      if (stall) begin
        chk("res_stable", {res_valid, res_match, res_addr},
            {1'b1, held});
      end
      if (res_valid && res_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL res_unexpected: got %0h want none",
                   {res_match, res_addr});
        end else begin
          e = exp_q.pop_front();
          chk("res_data", {res_match, res_addr}, e.r);
          chk("res_latency", cyc >= e.acc + 3, 1);
        end
      end
      stall = res_valid && !res_ready;
      held  = {res_match, res_addr};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int a1;
    int we_c;
    int n;
    int idx;
    int p0;
    bit seen;
    logic [31:0] keys3 [8];

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", all_out, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", lkp_ready, 1);

    // write then hit, exact latency
    do_write(5'd3, 32'hDEADBEEF, 0, 32'h0, we_c);
    lookup(32'hDEADBEEF, a);
    n = 0;
    do begin
      @(negedge clk);
      lkp_valid = 1'b0;
      #1;
      n++;
    end while (!res_valid && n < 10);
    chk("t1_latency", cyc - a, 3);
    wait_drain("t1_drain");

    // miss returns zero address
    lookup(32'h12345678, a);
    @(negedge clk);
    lkp_valid = 1'b0;
    wait_drain("t2_drain");

    // back-pressure: only depth lookups accepted
    do_write(5'd31, 32'hA5A5A5A5, 0, 32'h0, we_c);
    keys3[0] = 32'hDEADBEEF; keys3[1] = 32'hA5A5A5A5;
    keys3[2] = 32'h00000000; keys3[3] = 32'hDEADBEEF;
    keys3[4] = 32'h00000001; keys3[5] = 32'hA5A5A5A5;
    keys3[6] = 32'hDEADBEEF; keys3[7] = 32'h00000002;
    res_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lkp_valid = (idx < 8);
      lkp_key   = keys3[idx % 8];
      #1;
      if (lkp_valid && lkp_ready) begin
        push_exp(lkp_key);
        idx++;
      end
    end
    chk("t3_accepted", idx, 4);
    chk("t3_ready_low", lkp_ready, 0);
    p0 = pops;
    n = 0;
    while (idx < 8 && n < 100) begin
      @(negedge clk);
      res_ready = 1'b1;
      lkp_valid = 1'b1;
      lkp_key   = keys3[idx];
      #1;
      if (lkp_ready) begin
        push_exp(lkp_key);
        idx++;
      end
      n++;
    end
    @(negedge clk);
    lkp_valid = 1'b0;
    wait_drain("t3_drain");
    chk("t3_result_count", pops - p0, 8);

    // write waits for in-flight lookups
    lookup(32'hDEADBEEF, a1);
    lookup(32'hA5A5A5A5, a);
    chk("t4_back_to_back", a - a1, 1);
    do_write(5'd5, 32'h55555555, 0, 32'h0, we_c);
    chk("t4_we_after_push", we_c >= a + 4, 1);
    wait_drain("t4_drain");

    // simultaneous lookup and write: write wins
    do_write(5'd12, 32'h0BADF00D, 1, 32'h0BADF00D, we_c);
    lookup(32'h0BADF00D, a);
    @(negedge clk);
    lkp_valid = 1'b0;
    wait_drain("t5_drain");

    // reset during WAIT with queued results
    res_ready = 1'b0;
    lookup(32'hDEADBEEF, a);
    lookup(32'h00000003, a);
    lookup(32'h55555555, a);
    @(negedge clk);
    lkp_valid = 1'b0;
    wr_valid  = 1'b1;
    wr_addr   = 5'd7;
    wr_data   = 32'h77777777;
    #1;
    n = 0;
    while (!cam_we && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t6_we_seen", cam_we, 1);
    repeat (4) @(negedge clk);
    chk("t6_busy_in_wait", cam_busy, 1);
    rst      = 1'b1;
    wr_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("t6_reset_outputs", all_out, 0);
    rst       = 1'b0;
    res_ready = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      #1;
      if (wr_ready || res_valid) seen = 1;
    end
    chk("t6_no_stale", seen, 0);
    lookup(32'hDEADBEEF, a);
    @(negedge clk);
    lkp_valid = 1'b0;
    wait_drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
